// File: rtl/axi_b_resp_gen.sv
// AXI write-response generator: queues AW descriptors, counts memory beat completions,
// emits one registered B response per burst. Define AXI_B_RESP_GEN_SLVERR_EN to report SLVERR.
module axi_b_resp_gen #(
    parameter int IdWidth   = 4,
    parameter int UserWidth = 1,
    parameter int LenWidth  = 8,
    parameter int Depth     = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   aw_valid_i,
    output logic                   aw_ready_o,
    input  logic [IdWidth-1:0]     aw_id_i,
    input  logic [UserWidth-1:0]   aw_user_i,
    input  logic [LenWidth-1:0]    aw_len_i,
    input  logic                   mem_rsp_valid_i,
    output logic                   mem_rsp_ready_o,
    input  logic                   mem_rsp_err_i,
    output logic                   b_valid_o,
    input  logic                   b_ready_i,
    output logic [IdWidth-1:0]     b_id_o,
    output logic [1:0]             b_resp_o,
    output logic [UserWidth-1:0]   b_user_o,
    output logic [$clog2(Depth):0] usage_o
);
    localparam int PtrWidth = $clog2(Depth);
    localparam int CntWidth = PtrWidth + 1;

    logic [IdWidth-1:0]   id_q   [Depth];
    logic [UserWidth-1:0] user_q [Depth];
    logic [LenWidth-1:0]  len_q  [Depth];

    logic [PtrWidth-1:0] wr_ptr, rd_ptr;
    logic [CntWidth-1:0] usage_q;
    logic [LenWidth-1:0] beat_cnt;
    logic                push, beat, pop, last, not_empty;
    logic [1:0]          resp_next;

    logic                 b_valid_q;
    logic [IdWidth-1:0]   b_id_q;
    logic [UserWidth-1:0] b_user_q;
    logic [1:0]           b_resp_q;

    assign not_empty       = (usage_q != '0);
    assign aw_ready_o      = (usage_q != CntWidth'(Depth));
    assign last            = (beat_cnt == len_q[rd_ptr]);
    // The last beat may only complete when the B slot is free or draining this cycle.
    assign mem_rsp_ready_o = not_empty && (!last || !b_valid_q || b_ready_i);
    assign push            = aw_valid_i && aw_ready_o;
    assign beat            = mem_rsp_valid_i && mem_rsp_ready_o;
    assign pop             = beat && last;

    // Descriptor storage carries no reset; only the pointers and occupancy qualify it.
    always_ff @(posedge clk_i) begin
        if (push) begin
            id_q[wr_ptr]   <= aw_id_i;
            user_q[wr_ptr] <= aw_user_i;
            len_q[wr_ptr]  <= aw_len_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            usage_q  <= '0;
            beat_cnt <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PtrWidth'(1);
            if (pop)  rd_ptr <= rd_ptr + PtrWidth'(1);
            case ({push, pop})
                2'b10:   usage_q <= usage_q + CntWidth'(1);
                2'b01:   usage_q <= usage_q - CntWidth'(1);
                default: usage_q <= usage_q;
            endcase
            if (pop)       beat_cnt <= '0;
            else if (beat) beat_cnt <= beat_cnt + LenWidth'(1);
        end
    end

`ifdef AXI_B_RESP_GEN_SLVERR_EN
    logic err_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)     err_q <= 1'b0;
        else if (pop)  err_q <= 1'b0;
        else if (beat) err_q <= err_q | mem_rsp_err_i;
    end

    assign resp_next = (err_q | mem_rsp_err_i) ? 2'b10 : 2'b00;
`else
    logic unused_err;
    assign unused_err = mem_rsp_err_i;
    assign resp_next  = 2'b00;
`endif

    // B slot: a reload on the last beat takes priority over the clear on b_ready_i.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            b_valid_q <= 1'b0;
            b_id_q    <= '0;
            b_user_q  <= '0;
            b_resp_q  <= 2'b00;
        end else if (pop) begin
            b_valid_q <= 1'b1;
            b_id_q    <= id_q[rd_ptr];
            b_user_q  <= user_q[rd_ptr];
            b_resp_q  <= resp_next;
        end else if (b_ready_i) begin
            b_valid_q <= 1'b0;
        end
    end

    assign b_valid_o = b_valid_q;
    assign b_id_o    = b_id_q;
    assign b_user_o  = b_user_q;
    assign b_resp_o  = b_resp_q;
    assign usage_o   = usage_q;
endmodule

// File: tb/tb_axi_b_resp_gen.sv
// Directed self-checking bench for axi_b_resp_gen (default parameters).
module tb_axi_b_resp_gen;
    logic       clk = 1'b0;
    logic       rst;
    logic       aw_valid, aw_ready;
    logic [3:0] aw_id;
    logic [0:0] aw_user;
    logic [7:0] aw_len;
    logic       mem_rsp_valid, mem_rsp_ready, mem_rsp_err;
    logic       b_valid, b_ready;
    logic [3:0] b_id;
    logic [1:0] b_resp;
    logic [0:0] b_user;
    logic [2:0] usage;

    int vectors    = 0;
    int miscompares = 0;

`ifdef AXI_B_RESP_GEN_SLVERR_EN
    localparam logic [1:0] ErrResp = 2'b10;
`else
    localparam logic [1:0] ErrResp = 2'b00;
`endif

    axi_b_resp_gen dut (
        .clk_i(clk), .rst_i(rst),
        .aw_valid_i(aw_valid), .aw_ready_o(aw_ready),
        .aw_id_i(aw_id), .aw_user_i(aw_user), .aw_len_i(aw_len),
        .mem_rsp_valid_i(mem_rsp_valid), .mem_rsp_ready_o(mem_rsp_ready),
        .mem_rsp_err_i(mem_rsp_err),
        .b_valid_o(b_valid), .b_ready_i(b_ready),
        .b_id_o(b_id), .b_resp_o(b_resp), .b_user_o(b_user),
        .usage_o(usage)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [3:0] id, input logic [0:0] user, input logic [7:0] len);
        aw_valid = 1'b1; aw_id = id; aw_user = user; aw_len = len;
        tick();
        aw_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; aw_valid = 0; aw_id = 0; aw_user = 0; aw_len = 0;
        mem_rsp_valid = 0; mem_rsp_err = 0; b_ready = 0;
        tick(); tick();
        rst = 1'b0;
        tick();
        vectors++; if (aw_ready !== 1'b1) begin miscompares++; $display("FAIL reset_aw_ready got %0b exp 1", aw_ready); end
        vectors++; if (mem_rsp_ready !== 1'b0) begin miscompares++; $display("FAIL reset_mem_ready got %0b exp 0", mem_rsp_ready); end
        vectors++; if (usage !== 3'd0) begin miscompares++; $display("FAIL reset_usage got %0d exp 0", usage); end
        vectors++; if (b_valid !== 1'b0) begin miscompares++; $display("FAIL reset_b_valid got %0b exp 0", b_valid); end
        vectors++; if ({b_id, b_resp, b_user} !== 7'd0) begin miscompares++; $display("FAIL reset_b_fields got %h exp 0", {b_id, b_resp, b_user}); end
    endtask

    task automatic test_single();
        b_ready = 0;
        aw_valid = 1; aw_id = 4'd3; aw_user = 1'b1; aw_len = 8'd0;
        mem_rsp_valid = 1; mem_rsp_err = 0;
        #1;
        vectors++; if (mem_rsp_ready !== 1'b0) begin miscompares++; $display("FAIL single_no_fallthrough got %0b exp 0", mem_rsp_ready); end
        tick();
        aw_valid = 0;
        #1;
        vectors++; if (usage !== 3'd1) begin miscompares++; $display("FAIL single_usage got %0d exp 1", usage); end
        vectors++; if (mem_rsp_ready !== 1'b1) begin miscompares++; $display("FAIL single_mem_ready got %0b exp 1", mem_rsp_ready); end
        vectors++; if (b_valid !== 1'b0) begin miscompares++; $display("FAIL single_early_b got %0b exp 0", b_valid); end
        tick();
        mem_rsp_valid = 0;
        vectors++; if (b_valid !== 1'b1) begin miscompares++; $display("FAIL single_b_valid got %0b exp 1", b_valid); end
        vectors++; if (b_id !== 4'd3) begin miscompares++; $display("FAIL single_b_id got %0d exp 3", b_id); end
        vectors++; if (b_user !== 1'b1) begin miscompares++; $display("FAIL single_b_user got %0d exp 1", b_user); end
        vectors++; if (b_resp !== 2'b00) begin miscompares++; $display("FAIL single_b_resp got %b exp 00", b_resp); end
        vectors++; if (usage !== 3'd0) begin miscompares++; $display("FAIL single_usage_after got %0d exp 0", usage); end
        b_ready = 1;
        tick();
        vectors++; if (b_valid !== 1'b0) begin miscompares++; $display("FAIL single_b_clear got %0b exp 0", b_valid); end
        b_ready = 0;
    endtask

    task automatic test_error();
        b_ready = 0;
        push(4'd2, 1'b0, 8'd3);
        for (int i = 0; i < 4; i++) begin
            mem_rsp_valid = 1; mem_rsp_err = (i == 2);
            tick();
            if (i < 3) begin
                vectors++; if (b_valid !== 1'b0) begin miscompares++; $display("FAIL err_early_b beat %0d got %0b exp 0", i, b_valid); end
            end
        end
        mem_rsp_valid = 0; mem_rsp_err = 0;
        vectors++; if (b_valid !== 1'b1) begin miscompares++; $display("FAIL err_b_valid got %0b exp 1", b_valid); end
        vectors++; if (b_id !== 4'd2) begin miscompares++; $display("FAIL err_b_id got %0d exp 2", b_id); end
        vectors++; if (b_resp !== ErrResp) begin miscompares++; $display("FAIL err_b_resp got %b exp %b", b_resp, ErrResp); end
        b_ready = 1;
        tick();
        push(4'd4, 1'b0, 8'd0);
        mem_rsp_valid = 1;
        tick();
        mem_rsp_valid = 0;
        vectors++; if (b_id !== 4'd4) begin miscompares++; $display("FAIL err_clean_id got %0d exp 4", b_id); end
        vectors++; if (b_resp !== 2'b00) begin miscompares++; $display("FAIL err_flag_cleared got %b exp 00", b_resp); end
        tick();
    endtask

    task automatic test_full();
        b_ready = 1;
        for (int i = 0; i < 4; i++) push(4'(8 + i), 1'b0, 8'd0);
        vectors++; if (usage !== 3'd4) begin miscompares++; $display("FAIL full_usage got %0d exp 4", usage); end
        vectors++; if (aw_ready !== 1'b0) begin miscompares++; $display("FAIL full_aw_ready got %0b exp 0", aw_ready); end
        aw_valid = 1; aw_id = 4'd12; aw_user = 0; aw_len = 0;
        tick();
        vectors++; if (usage !== 3'd4) begin miscompares++; $display("FAIL full_held_off got %0d exp 4", usage); end
        mem_rsp_valid = 1;
        tick();
        mem_rsp_valid = 0;
        vectors++; if (aw_ready !== 1'b1) begin miscompares++; $display("FAIL full_slot_freed got %0b exp 1", aw_ready); end
        vectors++; if (b_id !== 4'd8 || b_valid !== 1'b1) begin miscompares++; $display("FAIL full_first_b got id %0d v %0b exp id 8 v 1", b_id, b_valid); end
        tick();
        aw_valid = 0;
        vectors++; if (usage !== 3'd4) begin miscompares++; $display("FAIL full_refill got %0d exp 4", usage); end
        mem_rsp_valid = 1;
        for (int i = 0; i < 4; i++) begin
            tick();
            vectors++; if (b_valid !== 1'b1 || b_id !== 4'(9 + i)) begin miscompares++; $display("FAIL full_drain_%0d got id %0d v %0b exp id %0d v 1", i, b_id, b_valid, 9 + i); end
        end
        mem_rsp_valid = 0;
        tick();
        vectors++; if (b_valid !== 1'b0 || usage !== 3'd0) begin miscompares++; $display("FAIL full_empty got v %0b usage %0d exp v 0 usage 0", b_valid, usage); end
    endtask

    task automatic test_backpressure();
        b_ready = 0;
        push(4'd4, 1'b0, 8'd0);
        push(4'd5, 1'b1, 8'd0);
        mem_rsp_valid = 1;
        tick();
        #1;
        vectors++; if (b_valid !== 1'b1 || b_id !== 4'd4) begin miscompares++; $display("FAIL bp_first got id %0d v %0b exp id 4 v 1", b_id, b_valid); end
        vectors++; if (mem_rsp_ready !== 1'b0) begin miscompares++; $display("FAIL bp_mem_ready got %0b exp 0", mem_rsp_ready); end
        for (int i = 0; i < 2; i++) begin
            tick();
            vectors++; if (b_valid !== 1'b1 || b_id !== 4'd4 || b_user !== 1'b0 || usage !== 3'd1) begin miscompares++; $display("FAIL bp_hold_%0d got id %0d v %0b usage %0d exp id 4 v 1 usage 1", i, b_id, b_valid, usage); end
        end
        b_ready = 1;
        #1;
        vectors++; if (mem_rsp_ready !== 1'b1) begin miscompares++; $display("FAIL bp_release got %0b exp 1", mem_rsp_ready); end
        tick();
        mem_rsp_valid = 0;
        vectors++; if (b_valid !== 1'b1 || b_id !== 4'd5 || b_user !== 1'b1) begin miscompares++; $display("FAIL bp_second got id %0d v %0b u %0d exp id 5 v 1 u 1", b_id, b_valid, b_user); end
        tick();
        vectors++; if (b_valid !== 1'b0) begin miscompares++; $display("FAIL bp_clear got %0b exp 0", b_valid); end
        b_ready = 0;
    endtask

    task automatic test_back_to_back_wrap();
        int sent = 0, got = 0, max_usage = 0;
        logic aw_hs;
        b_ready = 1;
        for (int cyc = 0; cyc < 200 && got < 10; cyc++) begin
            aw_valid = (sent < 10); aw_id = 4'(sent); aw_user = 1'(sent); aw_len = 8'd1;
            mem_rsp_valid = 1; mem_rsp_err = 0;
            #1;
            aw_hs = aw_valid && aw_ready;
            tick();
            if (aw_hs) sent++;
            if (int'(usage) > max_usage) max_usage = int'(usage);
            if (b_valid === 1'b1) begin
                vectors++; if (b_id !== 4'(got) || b_user !== 1'(got)) begin miscompares++; $display("FAIL wrap_order_%0d got id %0d u %0d exp id %0d", got, b_id, b_user, got); end
                got++;
            end
        end
        aw_valid = 0; mem_rsp_valid = 0;
        vectors++; if (got != 10) begin miscompares++; $display("FAIL wrap_count got %0d exp 10", got); end
        vectors++; if (max_usage > 4) begin miscompares++; $display("FAIL wrap_max_usage got %0d exp <= 4", max_usage); end
        tick();
        vectors++; if (usage !== 3'd0 || b_valid !== 1'b0) begin miscompares++; $display("FAIL wrap_idle got usage %0d v %0b exp 0 0", usage, b_valid); end
    endtask

    task automatic test_reset_mid_burst();
        int seen = 0;
        b_ready = 0;
        push(4'd6, 1'b0, 8'd0);
        push(4'd7, 1'b1, 8'd3);
        mem_rsp_valid = 1;
        for (int i = 0; i < 3; i++) tick();
        mem_rsp_valid = 0;
        vectors++; if (b_valid !== 1'b1 || usage !== 3'd1) begin miscompares++; $display("FAIL rst_pre got v %0b usage %0d exp v 1 usage 1", b_valid, usage); end
        rst = 1;
        #1;
        vectors++; if (b_valid !== 1'b0 || usage !== 3'd0) begin miscompares++; $display("FAIL rst_async got v %0b usage %0d exp 0 0", b_valid, usage); end
        tick(); tick();
        rst = 0;
        mem_rsp_valid = 1; b_ready = 1;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (b_valid === 1'b1 || mem_rsp_ready === 1'b1) seen++;
        end
        mem_rsp_valid = 0;
        vectors++; if (seen != 0) begin miscompares++; $display("FAIL rst_no_emit got %0d active cycles exp 0", seen); end
        push(4'd1, 1'b0, 8'd1);
        mem_rsp_valid = 1;
        tick();
        vectors++; if (b_valid !== 1'b0) begin miscompares++; $display("FAIL rst_cnt_cleared_early got %0b exp 0", b_valid); end
        tick();
        mem_rsp_valid = 0;
        vectors++; if (b_valid !== 1'b1 || b_id !== 4'd1) begin miscompares++; $display("FAIL rst_cnt_cleared got id %0d v %0b exp id 1 v 1", b_id, b_valid); end
        tick();
        b_ready = 0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_error();
        test_full();
        test_backpressure();
        test_back_to_back_wrap();
        test_reset_mid_burst();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/axi_b_resp_gen.md
# axi_b_resp_gen

Write-response generator for the AXI-to-memory bridge. It queues accepted AW burst descriptors and counts per-beat write completions returned by the memory side. When the last beat of the head burst completes, it produces one AXI B response with that burst's ID and user bits, holding it on a registered valid/ready output. It is the producer end of the write-response path and feeds the B-channel buffer in front of the AXI slave port.

## Interface
- IdWidth, 4: AXI ID width.
- UserWidth, 1: AXI user width; must be ≥1.
- LenWidth, 8: AXI burst length field width.
- Depth, 4: descriptor queue entries; power of two, ≥2.
- clk_i  input  1  clock; all logic rising-edge.
- rst_i  input  1  asynchronous, active-high reset.
- aw_valid_i  input  1  descriptor valid.
- aw_ready_o  output  1  descriptor accepted when high with aw_valid_i.
- aw_id_i  input  IdWidth  burst ID.
- aw_user_i  input  UserWidth  burst user bits.
- aw_len_i  input  LenWidth  beats minus one.
- mem_rsp_valid_i  input  1  one write beat completed by memory.
- mem_rsp_ready_o  output  1  beat completion accepted.
- mem_rsp_err_i  input  1  beat completed with error.
- b_valid_o  output  1  B response valid.
- b_ready_i  input  1  B response accepted.
- b_id_o  output  IdWidth  response ID.
- b_resp_o  output  2  response code (00 OKAY, 10 SLVERR).
- b_user_o  output  UserWidth  response user bits.
- usage_o  output  $clog2(Depth)+1  descriptors queued (not counting the B slot).

## Operation
- Descriptor queue: circular buffer, read/write pointers of $clog2(Depth) bits with wrap from Depth-1 to 0, occupancy counter of $clog2(Depth)+1 bits.
- aw_ready_o = (usage_o != Depth). Push when aw_valid_i && aw_ready_o.
- Beat state: beat counter (LenWidth bits) and sticky error flag, both for the head descriptor.
- mem_rsp_ready_o = queue non-empty && (!last || !b_valid_o || b_ready_i), where last = (beat counter == head aw_len).
- On beat handshake, not last: counter +1; error flag |= mem_rsp_err_i.
- On beat handshake, last: load the B slot with the head id and user, and b_resp = SLVERR if (error flag | mem_rsp_err_i), else OKAY; set b_valid_o; pop the head; clear the counter and error flag.
- B slot: single register. It holds stable while b_valid_o && !b_ready_i. It clears on b_ready_i unless it is reloaded in the same cycle.
- Simultaneous push and pop: occupancy unchanged and both pointers advance. Push into a full queue is impossible (ready low). Pop with the queue empty is impossible (mem_rsp_ready_o low).
- Beats arriving with no descriptor queued stall; they are not dropped.
- No flush input; only rst_i clears state.

## Timing
- Reset (async assert, sync release) sets: pointers = 0, occupancy = 0, beat counter = 0, error flag = 0, b_valid_o = 0, b_id_o = 0, b_resp_o = 00, b_user_o = 0. Resulting outputs: aw_ready_o = 1, mem_rsp_ready_o = 0, usage_o = 0.
- A descriptor pushed in cycle N is visible at the head in N+1. mem_rsp_ready_o can first rise in N+1 (no fall-through).
- Last beat accepted in cycle N gives b_valid_o = 1 in N+1 with all B fields valid.
- Back-to-back: with b_ready_i held high and len = 0 bursts, one B response per cycle.
- aw_ready_o depends only on registered occupancy. mem_rsp_ready_o depends combinationally on b_ready_i.
- Reset asserted mid-burst discards all queued descriptors, the partial beat count and any pending B response. Nothing is emitted after release.

## Configuration
- AXI_B_RESP_GEN_SLVERR_EN defined: error accumulation as above, so b_resp_o = 10 for any errored beat.
- Not defined: mem_rsp_err_i is ignored, the error flag is not implemented, and b_resp_o is constant 00.

## Test plan
- Single burst: AW id = 3, user = 1, len = 0; one beat with err = 0 -> next cycle b_valid_o = 1, b_id_o = 3, b_user_o = 1, b_resp_o = 00; b_ready_i = 1 clears it.
- Error accumulation (macro on): len = 3, err high on beat 2 only -> a single B with b_resp_o = 10 after beat 4. With the macro off, same stimulus -> b_resp_o = 00.
- Full queue: push 4 descriptors with no beats -> usage_o = 4, aw_ready_o = 0. A fifth aw_valid_i is held off. The first completed burst frees a slot, and aw_ready_o = 1 the next cycle.
- Backpressure: b_ready_i = 0 with two len = 0 bursts -> first B held with stable fields; mem_rsp_ready_o = 0 for the second burst's last beat until b_ready_i = 1, then the second B (id = 5) follows in the next cycle.
- Pointer wrap plus simultaneous push/pop: stream 10 len = 1 bursts with AW pushes overlapping pops -> 10 B responses in order with matching IDs, and usage_o never exceeds 4.
- Reset mid-burst: after 2 of 4 beats, pulse rst_i -> b_valid_o = 0, usage_o = 0, and no B is emitted after release.
